// File: rtl/parity_stream_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : parity_stream_checker                                      |
// | Description : Single-entry register stage that checks per-beat parity,   |
// |               flags errored beats, accumulates a per-frame error flag    |
// |               and keeps a saturating error counter plus a sticky flag.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk           : single clock, all state updates on its rising edge     |
// |   rst           : synchronous active-high reset                          |
// |   in_valid      : input beat present                                     |
// |   in_ready      : block accepts the input beat this cycle                |
// |   in_data       : data beat (DATA_W bits)                                |
// |   in_parity     : received parity bit for in_data                        |
// |   in_last       : final beat of a frame                                  |
// |   clr_err       : clear err_count and sticky_err                         |
// |   out_valid     : output beat present                                    |
// |   out_ready     : downstream accepts the output beat                     |
// |   out_data      : registered copy of the accepted in_data                |
// |   out_err       : parity error on the current output beat                |
// |   out_last      : registered copy of in_last                             |
// |   out_frame_err : frame ending on this beat had an error (last only)     |
// |   err_count     : saturating count of errored beats accepted (CNT_W)     |
// |   sticky_err    : an error has been seen since reset or clear            |
// +--------------------------------------------------------------------------+
module parity_stream_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  input  logic              in_last,
  input  logic              clr_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              out_last,
  output logic              out_frame_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              sticky_err
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_t;

  // Output register stage
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_err;
  logic              r_out_last;
  logic              r_out_frame_err;

  // Frame tracking
  frame_state_t      r_state;
  frame_state_t      w_state_nxt;
  logic              r_acc;
  logic              w_acc_nxt;
  logic              w_acc_cur;
  logic              w_frame_err;

  // Error statistics
  logic [CNT_W-1:0]  r_err_count;
  logic              r_sticky_err;

  // Beat-level handshake and parity
  logic              w_accept;
  logic              w_ones;
  logic              w_err;

  // The stage can take a new beat when it is empty or being drained now.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_ones = ^{in_data, in_parity};

  generate
    if (ODD != 0) begin : g_odd
      // Odd parity: an even number of ones across data+parity is an error.
      assign w_err = ~w_ones;
    end else begin : g_even
      assign w_err = w_ones;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Frame state and error accumulator
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_frame_err = 1'b0;
    // Only trust the accumulator inside a frame, so a fresh frame always
    // starts from a clean slate.
    w_acc_cur   = (r_state == ST_IN_FRAME) && r_acc;
    if (w_accept) begin
      if (in_last) begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = 1'b0;
        w_frame_err = w_acc_cur || w_err;
      end else begin
        w_state_nxt = ST_IN_FRAME;
        w_acc_nxt   = w_acc_cur || w_err;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_err       <= 1'b0;
      r_out_last      <= 1'b0;
      r_out_frame_err <= 1'b0;
    end else if (w_accept) begin
      r_out_valid     <= 1'b1;
      r_out_data      <= in_data;
      r_out_err       <= w_err;
      r_out_last      <= in_last;
      r_out_frame_err <= w_frame_err;
    end else if (out_ready) begin
      // Drained with nothing new behind it; payload fields may keep
      // their old values since out_valid qualifies them.
      r_out_valid     <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Saturating error counter and sticky flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count  <= '0;
      r_sticky_err <= 1'b0;
    end else if (w_accept && w_err) begin
      // A new error in the same cycle as a clear wins over the clear.
      if (clr_err) begin
        r_err_count <= c_CNT_ONE;
      end else if (r_err_count != c_CNT_MAX) begin
        r_err_count <= r_err_count + c_CNT_ONE;
      end
      r_sticky_err <= 1'b1;
    end else if (clr_err) begin
      r_err_count  <= '0;
      r_sticky_err <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_err       = r_out_err;
  assign out_last      = r_out_last;
  assign out_frame_err = r_out_frame_err;
  assign err_count     = r_err_count;
  assign sticky_err    = r_sticky_err;

endmodule
`default_nettype wire

// File: tb/tb_parity_stream_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_parity_stream_checker                                   |
// | Description : Scoreboard bench for parity_stream_checker (DATA_W=4,      |
// |               ODD=1, CNT_W=2) plus an even-parity instance.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_parity_stream_checker;

  typedef struct packed {
    logic [3:0] d;
    logic       e;
    logic       l;
    logic       f;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_parity;
  logic       in_last;
  logic       clr_err;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_err;
  logic       out_last;
  logic       out_frame_err;
  logic [1:0] err_count;
  logic       sticky_err;

  logic       e_in_valid;
  logic       e_in_ready;
  logic [3:0] e_in_data;
  logic       e_in_parity;
  logic       e_out_valid;
  logic [3:0] e_out_data;
  logic       e_out_err;
  logic       e_out_last;
  logic       e_out_frame_err;
  logic [1:0] e_err_count;
  logic       e_sticky_err;

  int   n_checks;
  int   n_fail;
  exp_t q[$];
  logic m_acc;

  parity_stream_checker #(.DATA_W(4), .ODD(1), .CNT_W(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_parity(in_parity), .in_last(in_last), .clr_err(clr_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_last(out_last), .out_frame_err(out_frame_err),
    .err_count(err_count), .sticky_err(sticky_err)
  );

  parity_stream_checker #(.DATA_W(4), .ODD(0), .CNT_W(2)) u_even (
    .clk(clk), .rst(rst),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data),
    .in_parity(e_in_parity), .in_last(1'b1), .clr_err(1'b0),
    .out_valid(e_out_valid), .out_ready(1'b1), .out_data(e_out_data),
    .out_err(e_out_err), .out_last(e_out_last), .out_frame_err(e_out_frame_err),
    .err_count(e_err_count), .sticky_err(e_sticky_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL out_beat: unexpected beat data=%h err=%b last=%b ferr=%b, none expected",
                 out_data, out_err, out_last, out_frame_err);
      end else begin
        exp_t x;
        x = q.pop_front();
        if ({out_data, out_err, out_last, out_frame_err} !== x) begin
          n_fail++;
          $display("FAIL out_beat: got data=%h err=%b last=%b ferr=%b, want data=%h err=%b last=%b ferr=%b",
                   out_data, out_err, out_last, out_frame_err, x.d, x.e, x.l, x.f);
        end
      end
    end
  end

  // Drive one beat, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [3:0] d, input logic p, input logic l, input logic e);
    int   waited;
    exp_t x;
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    in_last   = l;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waited);
    end else begin
      x.d = d;
      x.e = e;
      x.l = l;
      x.f = l ? (m_acc | e) : 1'b0;
      m_acc = l ? 1'b0 : (m_acc | e);
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_acc = 1'b0;
    n_checks++;
    if ({out_valid, out_data, out_err, out_last, out_frame_err, err_count, sticky_err} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h err=%b last=%b ferr=%b cnt=%0d sticky=%b, want all 0",
               out_valid, out_data, out_err, out_last, out_frame_err, err_count, sticky_err);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_parity();
    logic [3:0] d_t [4] = '{4'b1010, 4'b1111, 4'b0000, 4'b0101};
    logic       p_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       e_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(d_t[i], p_t[i], (i == 3), e_t[i]);
      n_checks++;
      if (out_valid !== 1'b1 || out_err !== e_t[i]) begin
        n_fail++;
        $display("FAIL parity_beat%0d: got valid=%b err=%b, want valid=1 err=%b", i, out_valid, out_err, e_t[i]);
      end
    end
    n_checks++;
    if (err_count !== 2'd2) begin
      n_fail++;
      $display("FAIL parity_count: got %0d want 2", err_count);
    end
  endtask

  task automatic test_frame();
    send(4'b1111, 1'b1, 1'b0, 1'b0);
    send(4'b1010, 1'b0, 1'b0, 1'b1);
    send(4'b0101, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (out_frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL frame3_err: got %b want 1", out_frame_err);
    end
    send(4'b1111, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (out_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame1_clean: got %b want 0", out_frame_err);
    end
    send(4'b0000, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (out_frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL frame1_err: got %b want 1", out_frame_err);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] c_t [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    n_checks++;
    if (err_count !== 2'd0 || sticky_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_only: got cnt=%0d sticky=%b, want 0 0", err_count, sticky_err);
    end
    for (int i = 0; i < 5; i++) begin
      send(4'b0000, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (err_count !== c_t[i] || sticky_err !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_count%0d: got cnt=%0d sticky=%b, want %0d 1", i, err_count, sticky_err, c_t[i]);
      end
    end
    clr_err = 1'b1;
    send(4'b1010, 1'b0, 1'b1, 1'b1);
    clr_err = 1'b0;
    n_checks++;
    if (err_count !== 2'd1 || sticky_err !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_vs_err: got cnt=%0d sticky=%b, want 1 1", err_count, sticky_err);
    end
  endtask

  task automatic test_backpressure();
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'b1111, 1'b1, 1'b0, 1'b0);
    in_valid  = 1'b1;
    in_data   = 4'b0011;
    in_parity = 1'b0;
    in_last   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || {out_valid, out_data, out_err, out_last, out_frame_err} !== 8'b1_1111_000) begin
        n_fail++;
        $display("FAIL stall%0d: got rdy=%b valid=%b data=%h err=%b last=%b ferr=%b, want rdy=0 valid=1 data=f err=0 last=0 ferr=0",
                 i, in_ready, out_valid, out_data, out_err, out_last, out_frame_err);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'b0011, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: %0d beats still expected, want 0", q.size());
    end
  endtask

  task automatic test_reset_midframe();
    send(4'b0000, 1'b0, 1'b0, 1'b1);
    send(4'b1111, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_acc = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || err_count !== 2'd0 || sticky_err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_reset: got valid=%b cnt=%0d sticky=%b rdy=%b, want 0 0 0 1",
               out_valid, err_count, sticky_err, in_ready);
    end
    out_ready = 1'b1;
    send(4'b1111, 1'b1, 1'b0, 1'b0);
    send(4'b0101, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (out_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_frame: got %b want 0", out_frame_err);
    end
  endtask

  task automatic test_even();
    logic [3:0] d_t [2] = '{4'b1010, 4'b1110};
    logic       e_t [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      e_in_valid  = 1'b1;
      e_in_data   = d_t[i];
      e_in_parity = 1'b0;
      @(posedge clk);
      #1;
      e_in_valid = 1'b0;
      n_checks++;
      if (e_out_valid !== 1'b1 || e_out_err !== e_t[i]) begin
        n_fail++;
        $display("FAIL even%0d: got valid=%b err=%b, want valid=1 err=%b", i, e_out_valid, e_out_err, e_t[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    m_acc       = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 4'h0;
    in_parity   = 1'b0;
    in_last     = 1'b0;
    clr_err     = 1'b0;
    out_ready   = 1'b1;
    e_in_valid  = 1'b0;
    e_in_data   = 4'h0;
    e_in_parity = 1'b0;
    test_reset();
    test_parity();
    test_frame();
    test_saturation();
    test_backpressure();
    test_reset_midframe();
    test_even();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d beats never appeared, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
